// File: rtl/next_pc_unit_pkg.sv
// Shared types for the next-PC unit: FSM states, redirect sources ordered by
// priority, and default reset/trap addresses.
package next_pc_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_FLUSH
  } state_e;

  // Numeric order is the redirect priority: a larger value wins.
  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JAL    = 3'd2,
    SRC_JALR   = 3'd3,
    SRC_MRET   = 3'd4,
    SRC_TRAP   = 3'd5
  } redirect_src_e;

  // A newer request replaces a pending one of equal or lower priority.
  function automatic logic src_wins(input redirect_src_e cur, input redirect_src_e pend);
    return (cur != SRC_NONE) && (cur >= pend);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational redirect selection: priority among current requests and any
// pending one, JALR bit-0 masking, and alignment check on the winning target.
module next_pc_sel
  import next_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC)
) (
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jal_i,
  input  logic [XLEN-1:0] jal_target_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            pend_valid_i,
  input  redirect_src_e   pend_src_i,
  input  logic [XLEN-1:0] pend_target_i,
  output logic            redir_valid_o,
  output redirect_src_e   redir_src_o,
  output logic [XLEN-1:0] redir_target_o,
  output logic            redir_misalign_o,
  output logic [XLEN-1:0] apply_target_o
);

  redirect_src_e   cur_src;
  redirect_src_e   pend_src;
  logic [XLEN-1:0] cur_target;

  always_comb begin
    cur_src    = SRC_NONE;
    cur_target = '0;
    if (trap_i) begin
      cur_src    = SRC_TRAP;
      cur_target = TRAP_VEC;
    end else if (mret_i) begin
      cur_src    = SRC_MRET;
      cur_target = epc_i;
    end else if (jalr_i) begin
      cur_src    = SRC_JALR;
      cur_target = {alu_result_i[XLEN-1:1], 1'b0};
    end else if (jal_i) begin
      cur_src    = SRC_JAL;
      cur_target = jal_target_i;
    end else if (branch_taken_i) begin
      cur_src    = SRC_BRANCH;
      cur_target = branch_target_i;
    end
  end

  always_comb begin
    pend_src = pend_valid_i ? pend_src_i : SRC_NONE;
    if (src_wins(cur_src, pend_src)) begin
      redir_src_o    = cur_src;
      redir_target_o = cur_target;
    end else begin
      redir_src_o    = pend_src;
      redir_target_o = pend_target_i;
    end
    redir_valid_o    = (redir_src_o != SRC_NONE);
    redir_misalign_o = redir_valid_o && (redir_target_o[1:0] != 2'b00);
    apply_target_o   = redir_misalign_o ? TRAP_VEC : redir_target_o;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC unit: fetch-address FSM (BOOT/RUN/HOLD/FLUSH) with a pending
// redirect register that collects requests while fetch is held.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jal_i,
  input  logic [XLEN-1:0] jal_target_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            pend_valid_q, pend_valid_d;
  redirect_src_e   pend_src_q, pend_src_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic            redir_valid;
  redirect_src_e   redir_src;
  logic [XLEN-1:0] redir_target;
  logic            redir_misalign;
  logic [XLEN-1:0] apply_target;
  logic            advance;
  logic [XLEN-1:0] pc_plus4;

  next_pc_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_sel (
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .jal_i            (jal_i),
    .jal_target_i     (jal_target_i),
    .jalr_i           (jalr_i),
    .alu_result_i     (alu_result_i),
    .trap_i           (trap_i),
    .mret_i           (mret_i),
    .epc_i            (epc_i),
    .pend_valid_i     (pend_valid_q),
    .pend_src_i       (pend_src_q),
    .pend_target_i    (pend_target_q),
    .redir_valid_o    (redir_valid),
    .redir_src_o      (redir_src),
    .redir_target_o   (redir_target),
    .redir_misalign_o (redir_misalign),
    .apply_target_o   (apply_target)
  );

  assign advance  = fetch_ready_i && !stall_i;
  assign pc_plus4 = pc_q + XLEN'(4);

  // The selector already merges pending with current requests, so RUN and
  // HOLD share one path; in RUN the pending register is always empty.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    flush_d         = 1'b0;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    pend_valid_d    = pend_valid_q;
    pend_src_d      = pend_src_q;
    pend_target_d   = pend_target_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (advance) begin
          pend_valid_d = 1'b0;
          pend_src_d   = SRC_NONE;
          if (redir_valid) begin
            pc_d    = apply_target;
            flush_d = 1'b1;
            state_d = ST_FLUSH;
            if (redir_misalign) begin
              misalign_d      = 1'b1;
              misalign_addr_d = redir_target;
            end
          end else begin
            pc_d    = pc_plus4;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_HOLD;
          if (redir_valid) begin
            pend_valid_d  = 1'b1;
            pend_src_d    = redir_src;
            pend_target_d = redir_target;
          end
        end
      end
      ST_FLUSH: begin
        state_d      = ST_RUN;
        pend_valid_d = 1'b0;
        pend_src_d   = SRC_NONE;
      end
      default: state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_PC;
      pc_valid_q      <= 1'b0;
      flush_q         <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      pend_valid_q    <= 1'b0;
      pend_src_q      <= SRC_NONE;
      pend_target_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_valid_q      <= pc_valid_d;
      flush_q         <= flush_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      pend_valid_q    <= pend_valid_d;
      pend_src_q      <= pend_src_d;
      pend_target_q   <= pend_target_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus4_o      = pc_plus4;
  assign pc_valid_o      = pc_valid_q;
  assign flush_o         = flush_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table through a scoreboard
// queue, plus a hand-written reset-during-HOLD sequence.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ready, br, jal, jalr, trap, mret;
  logic [31:0] br_t, jal_t, alu, epc;
  logic [31:0] pc, pc4, maddr;
  logic        pc_valid, flush, mis;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  next_pc_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .stall_i         (stall),
    .fetch_ready_i   (ready),
    .branch_taken_i  (br),
    .branch_target_i (br_t),
    .jal_i           (jal),
    .jal_target_i    (jal_t),
    .jalr_i          (jalr),
    .alu_result_i    (alu),
    .trap_i          (trap),
    .mret_i          (mret),
    .epc_i           (epc),
    .pc_o            (pc),
    .pc_plus4_o      (pc4),
    .pc_valid_o      (pc_valid),
    .flush_o         (flush),
    .misalign_o      (mis),
    .misalign_addr_o (maddr)
  );

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        f;
    logic        m;
    logic [31:0] ma;
  } exp_t;

  // kind: 0 none, 1 branch, 2 jal, 3 jalr, 4 mret, 5 trap, 6 trap+jalr
  typedef struct {
    logic        st;
    logic        rdy;
    logic [2:0]  kind;
    logic [31:0] tgt;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic st, input logic rdy, input logic [2:0] kind,
                              input logic [31:0] tgt, input logic [31:0] epc_v, input logic v,
                              input logic f, input logic m, input logic [31:0] ma);
    vec_t r;
    r.st = st; r.rdy = rdy; r.kind = kind; r.tgt = tgt;
    r.e.pc = epc_v; r.e.v = v; r.e.f = f; r.e.m = m; r.e.ma = ma;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive(input logic st, input logic rdy, input logic [2:0] kind, input logic [31:0] tgt);
    stall = st; ready = rdy;
    br = 1'b0; jal = 1'b0; jalr = 1'b0; trap = 1'b0; mret = 1'b0;
    br_t = 32'hDEAD_0010; jal_t = 32'hDEAD_0020; alu = 32'hDEAD_0030; epc = 32'hDEAD_0040;
    case (kind)
      3'd1: begin br = 1'b1; br_t = tgt; end
      3'd2: begin jal = 1'b1; jal_t = tgt; end
      3'd3: begin jalr = 1'b1; alu = tgt; end
      3'd4: begin mret = 1'b1; epc = tgt; end
      3'd5: trap = 1'b1;
      3'd6: begin trap = 1'b1; jalr = 1'b1; alu = tgt; end
      default: ;
    endcase
  endtask

  task automatic check_now(input string tag, input exp_t e);
    chk({tag, " pc"}, pc, e.pc);
    chk({tag, " pc_plus4"}, pc4, e.pc + 32'd4);
    chk({tag, " valid"}, {31'd0, pc_valid}, {31'd0, e.v});
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, e.f});
    chk({tag, " misalign"}, {31'd0, mis}, {31'd0, e.m});
    chk({tag, " misalign_addr"}, maddr, e.ma);
  endtask

  task automatic step(input vec_t r, input string tag);
    exp_t e;
    drive(r.st, r.rdy, r.kind, r.tgt);
    sb.push_back(r.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_now(tag, e);
    end
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0);

    //            st  rdy kind  tgt           exp pc        v  f  m  maddr
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0000, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0004, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0008, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd3, 32'h0000_1003, 32'h0000_0100, 0, 1, 1, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0100, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd3, 32'h0000_2001, 32'h0000_2000, 0, 1, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_2000, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_2004, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(1, 1, 3'd1, 32'h0000_0040, 32'h0000_2004, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(1, 1, 3'd2, 32'h0000_0080, 32'h0000_2004, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0080, 0, 1, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0080, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd6, 32'h0000_0300, 32'h0000_0100, 0, 1, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0100, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0000, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 0, 3'd1, 32'h0000_0044, 32'h0000_0000, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd4, 32'h0000_0500, 32'h0000_0500, 0, 1, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0500, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(1, 1, 3'd5, 32'h0,         32'h0000_0500, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(1, 1, 3'd3, 32'h0000_0600, 32'h0000_0500, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0040, 32'h0000_0100, 0, 1, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0100, 1, 0, 0, 32'h0000_1002));
    vecs.push_back(mk(0, 1, 3'd4, 32'h0000_0202, 32'h0000_0100, 0, 1, 1, 32'h0000_0202));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0100, 1, 0, 0, 32'h0000_0202));
    vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0040, 32'h0000_0040, 0, 1, 0, 32'h0000_0202));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0040, 1, 0, 0, 32'h0000_0202));
    vecs.push_back(mk(1, 1, 3'd0, 32'h0,         32'h0000_0040, 1, 0, 0, 32'h0000_0202));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0,         32'h0000_0044, 1, 0, 0, 32'h0000_0202));

    e.pc = 32'h0; e.v = 1'b0; e.f = 1'b0; e.m = 1'b0; e.ma = 32'h0;
    #2;
    check_now("reset", e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_now("boot", e);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Reset while HOLD has a pending branch: pending must be forgotten.
    step(mk(1, 1, 3'd1, 32'h0000_0040, 32'h0000_0044, 1, 0, 0, 32'h0000_0202), "hold_pend");
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst", e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_now("boot2", e);
    step(mk(0, 1, 3'd0, 32'h0, 32'h0000_0000, 1, 0, 0, 32'h0), "post_rst0");
    step(mk(0, 1, 3'd0, 32'h0, 32'h0000_0004, 1, 0, 0, 32'h0), "post_rst1");

    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, redirect target for trap and misaligned target.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 stall_i  input  1  pipeline hold request.
REQ-007 fetch_ready_i  input  1  fetch side accepts pc_o this cycle.
REQ-008 branch_taken_i  input  1  conditional branch resolved taken.
REQ-009 branch_target_i  input  XLEN  branch target.
REQ-010 jal_i  input  1  JAL executing.
REQ-011 jal_target_i  input  XLEN  JAL target.
REQ-012 jalr_i  input  1  JALR executing.
REQ-013 alu_result_i  input  XLEN  raw JALR sum rs1+imm.
REQ-014 trap_i  input  1  synchronous exception or interrupt taken.
REQ-015 mret_i  input  1  return from trap.
REQ-016 epc_i  input  XLEN  return address for mret.
REQ-017 pc_o  output  XLEN  current fetch address.
REQ-018 pc_plus4_o  output  XLEN  pc_o + 4, link value.
REQ-019 pc_valid_o  output  1  pc_o is a valid fetch request.
REQ-020 flush_o  output  1  one-cycle pulse: younger instructions killed.
REQ-021 misalign_o  output  1  one-cycle pulse: redirect target not 4-byte aligned.
REQ-022 misalign_addr_o  output  XLEN  offending target, held until next misalign.

Function
REQ-023 Redirect priority SHALL be trap > mret > jalr > jal > branch_taken > sequential (pc+4).
REQ-024 JALR target SHALL be alu_result_i with bit 0 forced to 0.
REQ-025 Selected redirect target with bits[1:0] != 0 SHALL NOT be taken; instead misalign_o=1, misalign_addr_o=target, next PC=TRAP_VEC.
REQ-026 Adder pc_o+4 SHALL wrap modulo 2^XLEN without error.
REQ-027 FSM states BOOT, RUN, HOLD, FLUSH.
REQ-028 BOOT: pc_valid_o=0, pc_o=RESET_PC; always -> RUN next cycle.
REQ-029 RUN: if advance (fetch_ready_i=1 and stall_i=0) PC updates to selected target; else -> HOLD, PC unchanged.
REQ-030 Any accepted redirect in RUN SHALL assert flush_o same cycle and -> FLUSH; FLUSH holds pc_valid_o=0 for one cycle then -> RUN.
REQ-031 HOLD: PC frozen; redirect arriving SHALL be latched in a pending register (target + valid), higher-priority later request overwriting lower, trap always overwriting.
REQ-032 HOLD exit on advance: pending target applied, flush_o pulsed, -> FLUSH; no pending -> RUN with sequential update.
REQ-033 Redirect present in the same cycle the stall releases SHALL be compared with pending by REQ-023 priority; winner applied, loser dropped.
REQ-034 flush_o and misalign_o SHALL never assert in BOOT.
REQ-035 Sequential update SHALL never occur in a cycle where a redirect is applied.

Reset
REQ-036 On rst_ni low, asynchronously: state=BOOT, pc_o=RESET_PC, pending valid=0, pc_valid_o=0, flush_o=0, misalign_o=0, misalign_addr_o=0.
REQ-037 Reset asserted mid-HOLD or mid-FLUSH SHALL discard pending redirect.

Structure
REQ-038 Shared package SHALL hold FSM state enum, redirect-source enum and priority encoding, default RESET_PC/TRAP_VEC.
REQ-039 One sub-module SHALL be natural: next_pc_sel, combinational priority select + JALR masking + alignment check; FSM and registers in next_pc_unit.

Verification
REQ-040 Reset release, fetch_ready_i=1 -> cycle0 pc_valid_o=0 pc_o=0; then 0x0, 0x4, 0x8 valid.
REQ-041 jalr_i=1, alu_result_i=0x0000_1003 -> misalign_o pulse, misalign_addr_o=0x0000_1002, next pc_o=0x100, flush_o=1.
REQ-042 jalr_i=1, alu_result_i=0x0000_2001 -> pc_o=0x0000_2000, flush_o one cycle, one bubble.
REQ-043 stall_i=1, branch_taken_i to 0x40 then jal to 0x80 during stall, release -> pc_o=0x80, single flush.
REQ-044 trap_i and jalr_i same cycle, target 0x300 -> pc_o=0x100; pc_o=0xFFFF_FFFC sequential -> 0x0.
REQ-045 rst_ni low during HOLD with pending 0x40 -> after release pc_o=0x0, no flush.
